// File: rtl/seg7_scan_decoder_pkg.sv
// Symbol alphabet and pattern constants for the 4-digit 7-segment display path.
// The display driver uses the same constants, so both ends always agree on the encoding.
package seg7_pkg;

  localparam logic [6:0] PAT_D = 7'b0100001;
  localparam logic [6:0] PAT_E = 7'b0000110;
  localparam logic [6:0] PAT_1 = 7'b1111001;
  localparam logic [6:0] PAT_0 = 7'b1000000;

  typedef enum logic [1:0] {
    SYM_D = 2'd0,
    SYM_E = 2'd1,
    SYM_1 = 2'd2,
    SYM_0 = 2'd3
  } sym_e;

  localparam logic [3:0] AN_BLANK = 4'b1111;

  // Digit enables are active-low, so one selected digit means exactly one zero bit.
  function automatic logic an_onehot_low(input logic [3:0] an);
    return $onehot(~an);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed display bus plus the recovered-frame results of the scan decoder.
// The master modport is the side that drives the display lines and reads back the results.
interface seg7_scan_decoder_if;

  logic [6:0] SEG7;
  logic [3:0] AN;
  logic       CLR;
  logic [7:0] CODE;
  logic [3:0] DIG_VALID;
  logic [1:0] ROT;
  logic       ROT_VALID;
  logic       ERR;

  modport master (
    output SEG7, AN, CLR,
    input  CODE, DIG_VALID, ROT, ROT_VALID, ERR
  );

  modport slave (
    input  SEG7, AN, CLR,
    output CODE, DIG_VALID, ROT, ROT_VALID, ERR
  );

endinterface

// File: rtl/seg7_scan_decoder_lookup.sv
// Combinational map from an active-low segment pattern to its 2-bit symbol code.
// An unknown pattern reports hit=0 and code=0.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg7,
  output logic       hit,
  output logic [1:0] code
);

  always_comb begin
    hit  = 1'b1;
    code = SYM_D;
    case (seg7)
      PAT_D:   code = SYM_D;
      PAT_E:   code = SYM_E;
      PAT_1:   code = SYM_1;
      PAT_0:   code = SYM_0;
      default: hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reader end of the multiplexed 7-segment display: debounces {AN,SEG7}, recovers per-digit
// symbol codes and reports which rotation of the message "dE10" is on display.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  seg7_scan_decoder_if.slave   bus
);

  logic [10:0]      smp_q, smp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       code_q, code_d;
  logic [3:0]       dig_valid_q, dig_valid_d;
  logic [1:0]       rot_q, rot_d;
  logic             rot_valid_q, rot_valid_d;
  logic             err_q, err_d;

  logic             same;
  logic             accept;
  logic [3:0]       smp_an;
  logic [6:0]       smp_seg;
  logic             hit;
  logic [1:0]       sym;
  logic [1:0]       idx;
  logic             rot_ok;

  assign smp_an  = smp_q[10:7];
  assign smp_seg = smp_q[6:0];

  seg7_pattern_lookup u_lookup (
    .seg7 (smp_seg),
    .hit  (hit),
    .code (sym)
  );

  // Accept fires only on the step into saturation, so a long hold yields a single accept.
  always_comb begin
    smp_d  = {bus.AN, bus.SEG7};
    same   = (smp_d == smp_q);
    cnt_d  = '0;
    if (same) begin
      cnt_d = (cnt_q == CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    accept = same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  end

  always_comb begin
    code_d      = code_q;
    dig_valid_d = dig_valid_q;
    err_d       = 1'b0;
    idx         = an_index(smp_an);
    if (accept && (smp_an != AN_BLANK)) begin
      if (an_onehot_low(smp_an)) begin
        if (hit) begin
          code_d[{idx, 1'b0} +: 2] = sym;
          dig_valid_d[idx]         = 1'b1;
        end else begin
          dig_valid_d[idx] = 1'b0;
          err_d            = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
    // Clear discards any same-cycle accept, but an illegal sample is still flagged.
    if (bus.CLR) begin
      code_d      = code_q;
      dig_valid_d = '0;
    end
  end

  // Consecutive digits must step by one (mod 4); digit 0 then carries the rotation.
  always_comb begin
    rot_ok = (dig_valid_q == 4'b1111) &&
             (code_q[3:2] == code_q[1:0] + 2'd1) &&
             (code_q[5:4] == code_q[1:0] + 2'd2) &&
             (code_q[7:6] == code_q[1:0] + 2'd3);
    rot_valid_d = rot_ok;
    rot_d       = rot_ok ? code_q[1:0] : rot_q;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      smp_q       <= '1;
      cnt_q       <= '0;
      code_q      <= '0;
      dig_valid_q <= '0;
      rot_q       <= '0;
      rot_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      smp_q       <= smp_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      dig_valid_q <= dig_valid_d;
      rot_q       <= rot_d;
      rot_valid_q <= rot_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.CODE      = code_q;
  assign bus.DIG_VALID = dig_valid_q;
  assign bus.ROT       = rot_q;
  assign bus.ROT_VALID = rot_valid_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: each held display value pushes its expected
// frame state, which is popped and compared once the hold window has elapsed.
module tb_seg7_scan_decoder;

  localparam logic [6:0] P_D     = 7'b0100001;
  localparam logic [6:0] P_E     = 7'b0000110;
  localparam logic [6:0] P_1     = 7'b1111001;
  localparam logic [6:0] P_0     = 7'b1000000;
  localparam logic [6:0] P_BLANK = 7'b1111111;

  typedef struct {
    string      tag;
    logic [7:0] code;
    logic [3:0] dv;
    logic [1:0] rot;
    logic       rotv;
    int         errs;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   errSeen;

  exp_t        sb[$];
  logic [1:0]  mCode[4];
  logic [3:0]  mDv;
  logic [1:0]  mRot;
  logic        mRotv;
  logic [10:0] mPrev;

  seg7_scan_decoder_if bus ();

  seg7_scan_decoder dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ERR === 1'b1) errSeen++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] modelCode();
    return {mCode[3], mCode[2], mCode[1], mCode[0]};
  endfunction

  // Reference model: the digit-to-rotation relation is searched over every k directly.
  function automatic void modelRotation();
    logic ok;
    mRotv = 1'b0;
    if (mDv == 4'b1111) begin
      for (int k = 0; k < 4; k++) begin
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (mCode[i] != 2'((i + k) % 4)) ok = 1'b0;
        end
        if (ok) begin
          mRotv = 1'b1;
          mRot  = 2'(k);
        end
      end
    end
  endfunction

  // Called at #1 after a rising edge; holds {an,seg} for 'cycles' edges, optionally with CLR on the accept edge.
  task automatic applyStimulus(input string tag, input logic [3:0] an, input logic [6:0] seg,
                               input int cycles, input bit clrAtAccept);
    exp_t       e;
    exp_t       got;
    logic [7:0] oldCode;
    logic [3:0] oldDv;
    bit         acc;
    int         zeros;
    int         pos;
    logic [1:0] sym;
    bit         known;

    oldCode = modelCode();
    oldDv   = mDv;
    acc     = ({an, seg} != mPrev) && (cycles >= 5);
    e.errs  = 0;
    zeros   = 0;
    pos     = 0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) begin
        zeros++;
        pos = i;
      end
    end
    known = 1'b1;
    sym   = 2'd0;
    case (seg)
      P_D:     sym = 2'd0;
      P_E:     sym = 2'd1;
      P_1:     sym = 2'd2;
      P_0:     sym = 2'd3;
      default: known = 1'b0;
    endcase
    if (acc && an != 4'b1111) begin
      if (zeros == 1) begin
        if (known) begin
          if (!clrAtAccept) begin
            mCode[pos] = sym;
            mDv[pos]   = 1'b1;
          end
        end else begin
          if (!clrAtAccept) mDv[pos] = 1'b0;
          e.errs = 1;
        end
      end else begin
        e.errs = 1;
      end
    end
    if (clrAtAccept && cycles >= 5) mDv = 4'b0000;
    mPrev = {an, seg};
    modelRotation();
    e.tag  = tag;
    e.code = modelCode();
    e.dv   = mDv;
    e.rot  = mRot;
    e.rotv = mRotv;
    sb.push_back(e);

    bus.AN   = an;
    bus.SEG7 = seg;
    errSeen  = 0;
    for (int c = 1; c <= cycles; c++) begin
      bus.CLR = clrAtAccept && (c == 5);
      @(negedge clk);
      if (c == 5) begin
        checkOutput({tag, "_dv_pre_accept"}, 32'(bus.DIG_VALID), 32'(oldDv));
        checkOutput({tag, "_code_pre_accept"}, 32'(bus.CODE), 32'(oldCode));
      end
      @(posedge clk);
      #1;
    end
    bus.CLR = 1'b0;

    got = sb.pop_front();
    checkOutput({got.tag, "_code"}, 32'(bus.CODE), 32'(got.code));
    checkOutput({got.tag, "_dv"}, 32'(bus.DIG_VALID), 32'(got.dv));
    checkOutput({got.tag, "_rot"}, 32'(bus.ROT), 32'(got.rot));
    checkOutput({got.tag, "_rotv"}, 32'(bus.ROT_VALID), 32'(got.rotv));
    checkOutput({got.tag, "_errs"}, 32'(errSeen), 32'(got.errs));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mCode[i] = 2'd0;
    mDv   = 4'b0000;
    mRot  = 2'd0;
    mRotv = 1'b0;
    mPrev = 11'h7FF;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_code"}, 32'(bus.CODE), 32'h0);
    checkOutput({tag, "_dv"}, 32'(bus.DIG_VALID), 32'h0);
    checkOutput({tag, "_rot"}, 32'(bus.ROT), 32'h0);
    checkOutput({tag, "_rotv"}, 32'(bus.ROT_VALID), 32'h0);
    checkOutput({tag, "_err"}, 32'(bus.ERR), 32'h0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    errSeen  = 0;
    rst_n    = 1'b0;
    bus.AN   = 4'b1111;
    bus.SEG7 = P_BLANK;
    bus.CLR  = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("t1_d0", 4'b1110, P_D, 6, 1'b0);

    applyStimulus("t2_e1", 4'b1101, P_E, 6, 1'b0);
    applyStimulus("t2_one2", 4'b1011, P_1, 6, 1'b0);
    applyStimulus("t2_zero3", 4'b0111, P_0, 6, 1'b0);
    applyStimulus("t2_blank", 4'b1111, P_BLANK, 6, 1'b0);

    applyStimulus("s2_one0", 4'b1110, P_1, 6, 1'b0);
    applyStimulus("s2_zero1", 4'b1101, P_0, 6, 1'b0);
    applyStimulus("s2_d2", 4'b1011, P_D, 6, 1'b0);
    applyStimulus("s2_e3", 4'b0111, P_E, 6, 1'b0);

    applyStimulus("t3_badseg", 4'b1011, P_BLANK, 6, 1'b0);
    applyStimulus("t4_twohot", 4'b1100, P_D, 8, 1'b0);

    applyStimulus("t5_d0", 4'b1110, P_D, 6, 1'b0);
    applyStimulus("t5_glitch", 4'b1110, P_0, 2, 1'b0);
    applyStimulus("t5_d0_back", 4'b1110, P_D, 6, 1'b0);

    applyStimulus("t6_refill2", 4'b1011, P_1, 6, 1'b0);
    applyStimulus("t6_clr", 4'b1101, P_1, 6, 1'b1);
    applyStimulus("t6_refill0", 4'b1110, P_E, 6, 1'b0);
    applyStimulus("t6_refill1", 4'b1101, P_0, 3, 1'b0);

    #3;
    rst_n    = 1'b0;
    bus.AN   = 4'b1111;
    bus.SEG7 = P_BLANK;
    modelReset();
    #1;
    checkResetState("t6_midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("post_reset_e3", 4'b0111, P_E, 6, 1'b0);

    if (sb.size() != 0) checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
